mem_access_unit: RTL and testbench

Multi-cycle load/store front end that sits directly upstream of the byte-addressable data RAM in the multi-cyclic MIPS datapath. Accepts one load or store request at a time from the control unit, drives the RAM address/data/write-enable/size-select, and returns a registered, sign- or zero-extended load result (memory data register). Optionally flags misaligned half/word accesses and suppresses them.

---
 rtl/mau_pkg.sv | 39 +++
 rtl/mem_access_unit_load_extender.sv | 38 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mau_pkg
// Description : Shared definitions for the memory access unit: RAM size-select
//               encodings, the access FSM state type and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mau_pkg;

    // RAM size-select encodings (match the RAM "sel" input)
    localparam logic [1:0] c_WW = 2'b00;   // word
    localparam logic [1:0] c_WH = 2'b01;   // half
    localparam logic [1:0] c_WB = 2'b10;   // byte

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The unused encoding 2'b11 behaves as a byte access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? c_WB : size;
    endfunction

    // Half needs addr[0]=0, word needs addr[1:0]=00; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        if (size == c_WH)
            r = addr_lo[0];
        else if (size == c_WW)
            r = (addr_lo != 2'b00);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extender.sv
`default_nettype none
// ============================================================================
// Module      : load_extender
// Description : Combinational load-data extension. Selects the low byte, low
//               half or full word of the RAM read data and sign- or
//               zero-extends it to 32 bits.
// Ports       : i_data  - raw RAM read word
//               i_size  - normalised access size (WW/WH/WB)
//               i_uns   - 1 = zero-extend, 0 = sign-extend (ignored for words)
//               o_data  - extended result
// Revision    : 1.0 - initial release
// ============================================================================
module load_extender
    import mau_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_data
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_uns & i_data[7];
    assign w_sign_h = ~i_uns & i_data[15];

    always_comb begin
        o_data = i_data;
        case (i_size)
            c_WB:    o_data = {{24{w_sign_b}}, i_data[7:0]};
            c_WH:    o_data = {{16{w_sign_h}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Multi-cycle load/store front end for a byte-addressable data
//               RAM. One request at a time: IDLE captures the request, ACCESS
//               drives the RAM (write strobe for stores, read sample for
//               loads), RESP pulses o_done. Load data is extended and held in
//               o_rdata until the next load completes.
// Options     : MAU_ALIGN_CHECK_EN - when defined, misaligned half/word
//               accesses are suppressed (no write, rdata kept) and flagged on
//               o_misaligned together with o_done. When undefined,
//               o_misaligned is always 0 and every address goes to the RAM.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               i_req        - request strobe (sampled in IDLE only)
//               i_we         - 1 store / 0 load
//               i_size       - 00 word, 01 half, 10/11 byte
//               i_uns        - load zero-extend when 1
//               i_addr       - byte address
//               i_wdata      - store data, right-aligned
//               o_busy       - high in ACCESS and RESP
//               o_done       - one-cycle completion pulse
//               o_rdata      - extended load result
//               o_misaligned - access suppressed, valid with o_done
//               o_ram_*      - RAM address/data/write-enable/size-select
//               i_ram_rdata  - RAM combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic                     i_we,
    input  logic [1:0]               i_size,
    input  logic                     i_uns,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [DATA_WIDTH-1:0]    o_rdata,
    output logic                     o_misaligned,
    output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0]    o_ram_data,
    output logic                     o_ram_w_en,
    output logic [1:0]               o_ram_sel,
    input  logic [DATA_WIDTH-1:0]    i_ram_rdata
);

    state_t                   r_state;
    logic                     r_we;
    logic [1:0]               r_size;
    logic                     r_uns;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic                     r_mis;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_misaligned;
    logic                     r_ram_w_en;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic [1:0]               w_size_n;
    logic                     w_mis;
    logic [DATA_WIDTH-1:0]    w_ext;

    assign w_size_n = norm_size(i_size);

    // Alignment is judged on the incoming request so the write strobe can be
    // registered (and therefore glitch-free) on entry to ACCESS.
`ifdef MAU_ALIGN_CHECK_EN
    assign w_mis = is_misaligned(w_size_n, i_addr[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    load_extender u_load_extender (
        .i_data (i_ram_rdata),
        .i_size (r_size),
        .i_uns  (r_uns),
        .o_data (w_ext)
    );

    // Single FSM; every output is a register so the asynchronous reset
    // clears the RAM write strobe immediately, even mid-ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= c_WW;
            r_uns        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mis        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_ram_w_en   <= 1'b0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_we       <= i_we;
                        r_size     <= w_size_n;
                        r_uns      <= i_uns;
                        r_addr     <= i_addr;
                        r_wdata    <= i_wdata;
                        r_mis      <= w_mis;
                        r_busy     <= 1'b1;
                        r_ram_w_en <= i_we & ~w_mis;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_ram_w_en <= 1'b0;
                    if (!r_we && !r_mis)
                        r_rdata <= w_ext;
                    r_done       <= 1'b1;
                    r_misaligned <= r_mis;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_done       <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_done       <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_busy       <= 1'b0;
                    r_ram_w_en   <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_rdata      = r_rdata;
    assign o_misaligned = r_misaligned;
    assign o_ram_addr   = r_addr;
    assign o_ram_data   = r_wdata;
    assign o_ram_w_en   = r_ram_w_en;
    assign o_ram_sel    = r_size;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               little-endian byte-addressed RAM model attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_we, i_uns;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata;
    logic        o_busy, o_done, o_misaligned, o_ram_w_en;
    logic [31:0] o_rdata, o_ram_addr, o_ram_data, i_ram_rdata;
    logic [1:0]  o_ram_sel;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_size       (i_size),
        .i_uns        (i_uns),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned),
        .o_ram_addr   (o_ram_addr),
        .o_ram_data   (o_ram_data),
        .o_ram_w_en   (o_ram_w_en),
        .o_ram_sel    (o_ram_sel),
        .i_ram_rdata  (i_ram_rdata)
    );

    // ---------------- RAM model (256 bytes, little-endian) ----------------
    logic [7:0] mem [0:255];
    logic       mem_clr;
    logic [7:0] a0;
    assign a0 = o_ram_addr[7:0];
    assign i_ram_rdata = {mem[a0 + 8'd3], mem[a0 + 8'd2], mem[a0 + 8'd1], mem[a0]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
        end else if (o_ram_w_en) begin
            mem[a0] <= o_ram_data[7:0];
            if (o_ram_sel == 2'b00 || o_ram_sel == 2'b01)
                mem[a0 + 8'd1] <= o_ram_data[15:8];
            if (o_ram_sel == 2'b00) begin
                mem[a0 + 8'd2] <= o_ram_data[23:16];
                mem[a0 + 8'd3] <= o_ram_data[31:24];
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One complete transaction. Starts #1 after a posedge with the DUT idle,
    // returns #1 after the posedge that brings it back to IDLE.
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output int wen, output logic mis,
                             output logic [1:0] sel);
        i_we = we; i_size = size; i_uns = uns; i_addr = addr; i_wdata = wdata;
        i_req = 1'b1;
        lat = 0; wen = 0; mis = 1'b0; sel = 2'b11;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (o_ram_w_en) wen++;
            if (o_busy && !o_done) sel = o_ram_sel;
            @(posedge clk); #1;
            i_req = 1'b0;
            if (o_done) begin
                lat = i;
                mis = o_misaligned;
                break;
            end
        end
        if (lat == 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    int          lat, wen, dones;
    logic        mis;
    logic [1:0]  sel;

    initial begin
        rst_n = 1'b0; mem_clr = 1'b1;
        i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_uns = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_busy",  {31'd0, o_busy}, 32'd0);
        check("rst_done",  {31'd0, o_done}, 32'd0);
        check("rst_mis",   {31'd0, o_misaligned}, 32'd0);
        check("rst_wen",   {31'd0, o_ram_w_en}, 32'd0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_raddr", o_ram_addr, 32'h0);
        check("rst_rdat",  o_ram_data, 32'h0);
        check("rst_sel",   {30'd0, o_ram_sel}, 32'd0);
        mem_clr = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // store word, then load it back
        do_access(1'b1, 2'b00, 1'b0, 32'h40, 32'hDEADBEEF, lat, wen, mis, sel);
        check("sw_latency", lat, 2);
        check("sw_wen_cnt", wen, 1);
        check("sw_sel",     {30'd0, sel}, 32'd0);
        check("sw_rdata_kept", o_rdata, 32'h0);
        do_access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, lat, wen, mis, sel);
        check("lw_latency", lat, 2);
        check("lw_wen_cnt", wen, 0);
        check("lw_rdata",   o_rdata, 32'hDEADBEEF);

        // byte / half extension
        do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, wen, mis, sel);
        check("lb_signed",   o_rdata, 32'hFFFFFFEF);
        do_access(1'b0, 2'b10, 1'b1, 32'h40, 32'h0, lat, wen, mis, sel);
        check("lbu",         o_rdata, 32'h000000EF);
        do_access(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, lat, wen, mis, sel);
        check("lh_signed",   o_rdata, 32'hFFFFDEAD);
        do_access(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, lat, wen, mis, sel);
        check("lhu",         o_rdata, 32'h0000DEAD);

        // byte store with size=11
        do_access(1'b1, 2'b11, 1'b0, 32'h41, 32'hAABBCC12, lat, wen, mis, sel);
        check("sb_sel",      {30'd0, sel}, 32'd2);
        check("sb_wen_cnt",  wen, 1);
        check("sb_rdata_kept", o_rdata, 32'h0000DEAD);
        do_access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, lat, wen, mis, sel);
        check("lw_after_sb", o_rdata, 32'hDEAD12EF);

        // req held high: accepted every third cycle
        i_we = 1'b0; i_size = 2'b00; i_uns = 1'b0; i_addr = 32'h40;
        i_req = 1'b1;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (o_done) begin
                dones++;
                check("busy_with_done", {31'd0, o_busy}, 32'd1);
            end
        end
        i_req = 1'b0;
        check("held_done_count", dones, 4);
        check("held_rdata", o_rdata, 32'hDEAD12EF);

        // misaligned word store at 0x42, then a misaligned half load at 0x41
        do_access(1'b1, 2'b00, 1'b0, 32'h42, 32'h11223344, lat, wen, mis, sel);
`ifdef MAU_ALIGN_CHECK_EN
        check("mis_sw_wen", wen, 0);
        check("mis_sw_flag", {31'd0, mis}, 32'd1);
        check("mis_sw_rdata", o_rdata, 32'hDEAD12EF);
        do_access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, lat, wen, mis, sel);
        check("mis_lw40", o_rdata, 32'hDEAD12EF);
        do_access(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, lat, wen, mis, sel);
        check("mis_lh_flag", {31'd0, mis}, 32'd1);
        check("mis_lh_rdata", o_rdata, 32'hDEAD12EF);
`else
        check("mis_sw_wen", wen, 1);
        check("mis_sw_flag", {31'd0, mis}, 32'd0);
        do_access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, lat, wen, mis, sel);
        check("mis_lw40", o_rdata, 32'h334412EF);
        do_access(1'b0, 2'b00, 1'b0, 32'h44, 32'h0, lat, wen, mis, sel);
        check("mis_lw44", o_rdata, 32'h00001122);
        do_access(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, lat, wen, mis, sel);
        check("mis_lh_flag", {31'd0, mis}, 32'd0);
        check("mis_lh_rdata", o_rdata, 32'h00004412);
`endif

        // reset asserted in the ACCESS cycle of a store
        i_we = 1'b1; i_size = 2'b00; i_uns = 1'b0; i_addr = 32'h80; i_wdata = 32'hCAFEF00D;
        i_req = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b0;
        check("pre_rst_wen", {31'd0, o_ram_w_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wen",   {31'd0, o_ram_w_en}, 32'd0);
        check("arst_busy",  {31'd0, o_busy}, 32'd0);
        check("arst_done",  {31'd0, o_done}, 32'd0);
        check("arst_rdata", o_rdata, 32'h0);
        check("arst_raddr", o_ram_addr, 32'h0);
        check("arst_rdat",  o_ram_data, 32'h0);
        check("arst_sel",   {30'd0, o_ram_sel}, 32'd0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, lat, wen, mis, sel);
        check("arst_mem_unchanged", o_rdata, 32'h0);
        do_access(1'b1, 2'b00, 1'b0, 32'h80, 32'h12345678, lat, wen, mis, sel);
        check("post_rst_sw_lat", lat, 2);
        do_access(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, lat, wen, mis, sel);
        check("post_rst_lw", o_rdata, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
